// File: rtl/key_event_gen_if.sv
// Key event bus: debounced key level and repeat enable in, event pulses and held level out.
// The slave modport is the key_event_gen side; master is the side that drives the key.
interface key_event_gen_if;
    logic key_i;
    logic repeat_en_i;
    logic press_o;
    logic release_o;
    logic long_press_o;
    logic rpt_o;
    logic held_o;
    logic double_click_o;

    modport slave (
        input  key_i,
        input  repeat_en_i,
        output press_o,
        output release_o,
        output long_press_o,
        output rpt_o,
        output held_o,
        output double_click_o
    );

    modport master (
        output key_i,
        output repeat_en_i,
        input  press_o,
        input  release_o,
        input  long_press_o,
        input  rpt_o,
        input  held_o,
        input  double_click_o
    );
endinterface

// File: rtl/key_event_gen.sv
// key_event_gen: turns a clean, clk-synchronous key level into registered one-cycle
// press / release / long-press / auto-repeat pulses plus a held level. One instance per key.
// Optional double-click detection is compiled in when DOUBLE_CLICK_EN is defined;
// otherwise double_click_o is tied low and the window logic is absent.
module key_event_gen #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned DCLICK_CYCLES = 25_000_000,
    parameter int unsigned CNT_W         = 27
) (
    input logic            clk,
    input logic            rst_n,
    key_event_gen_if.slave ev_io
);

    // Reject thresholds the counters cannot reach or that would collapse the timing.
    if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2 ||
        64'(LONG_CYCLES) > (64'd1 << CNT_W) || 64'(REPEAT_CYCLES) > (64'd1 << CNT_W) ||
        64'(DCLICK_CYCLES) > (64'd1 << CNT_W)) begin : g_param_check
        $error("key_event_gen: invalid cycle parameters");
    end

    // Counters hold (edges since reference - 1), so a threshold of N fires when cnt_q == N-1.
    localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] RptLast  = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StShort, StLong} state_e;

    state_e           state_q, state_d;
    logic             key_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;  // repeat reference edge has been taken in LONG
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             rpt_q, rpt_d;
    logic             held_q, held_d;

    // Next-state and event decode; release always wins over a coincident threshold.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        armed_d   = armed_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        rpt_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ev_io.key_i && !key_q) begin
                    press_d = 1'b1;
                    state_d = StShort;
                    cnt_d   = '0;
                end
            end
            StShort: begin
                if (!ev_io.key_i) begin
                    release_d = 1'b1;
                    state_d   = StIdle;
                    cnt_d     = '0;
                end else if (cnt_q == LongLast) begin
                    long_d  = 1'b1;
                    state_d = StLong;
                    cnt_d   = '0;
                    armed_d = ev_io.repeat_en_i;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLong: begin
                if (!ev_io.key_i) begin
                    release_d = 1'b1;
                    state_d   = StIdle;
                    cnt_d     = '0;
                    armed_d   = 1'b0;
                end else if (!ev_io.repeat_en_i) begin
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end else if (!armed_q) begin
                    // First edge sampling repeat_en=1 becomes the repeat reference.
                    cnt_d   = '0;
                    armed_d = 1'b1;
                end else if (cnt_q == RptLast) begin
                    rpt_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                armed_d = 1'b0;
            end
        endcase
        held_d = (state_d != StIdle);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            key_q     <= 1'b0;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            rpt_q     <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= ev_io.key_i;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            rpt_q     <= rpt_d;
            held_q    <= held_d;
        end
    end

    assign ev_io.press_o      = press_q;
    assign ev_io.release_o    = release_q;
    assign ev_io.long_press_o = long_q;
    assign ev_io.rpt_o        = rpt_q;
    assign ev_io.held_o       = held_q;

`ifdef DOUBLE_CLICK_EN
    localparam logic [CNT_W-1:0] DclickLast = CNT_W'(DCLICK_CYCLES - 1);

    logic             win_open_q, win_open_d;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic             dclick_q, dclick_d;

    // Double-click window: opened by a release from SHORT, closed by any press or expiry.
    always_comb begin
        win_open_d = win_open_q;
        win_cnt_d  = win_cnt_q;
        dclick_d   = 1'b0;
        if (press_d) begin
            dclick_d   = win_open_q;
            win_open_d = 1'b0;
            win_cnt_d  = '0;
        end else if (release_d) begin
            win_open_d = (state_q == StShort);
            win_cnt_d  = '0;
        end else if (win_open_q) begin
            if (win_cnt_q == DclickLast) begin
                win_open_d = 1'b0;
                win_cnt_d  = '0;
            end else begin
                win_cnt_d = win_cnt_q + 1'b1;
            end
        end
    end

    // Window state and registered double-click pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_open_q <= 1'b0;
            win_cnt_q  <= '0;
            dclick_q   <= 1'b0;
        end else begin
            win_open_q <= win_open_d;
            win_cnt_q  <= win_cnt_d;
            dclick_q   <= dclick_d;
        end
    end

    assign ev_io.double_click_o = dclick_q;
`else
    assign ev_io.double_click_o = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with LONG=8, REPEAT=4, DCLICK=6.
// Expected output vector per edge is {press, release, long_press, rpt, held, double_click}.
module tb_key_event_gen;

`ifdef DOUBLE_CLICK_EN
    localparam bit DcOn = 1'b1;
`else
    localparam bit DcOn = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    key_event_gen_if bus ();

    key_event_gen #(
        .LONG_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .DCLICK_CYCLES(6),
        .CNT_W        (27)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ev_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {bus.press_o, bus.release_o, bus.long_press_o, bus.rpt_o, bus.held_o,
                bus.double_click_o};
    endfunction

    task automatic chk(input string tag, input int e, input logic [5:0] obs,
                       input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s@%0d: observed %b expected %b", tag, e, obs, exp);
        end
    endtask

    // Drive inputs (called just after a negedge), take one rising edge, check at the negedge.
    task automatic step(input logic k, input logic r, input logic [5:0] exp, input string tag,
                        input int e);
        bus.key_i       = k;
        bus.repeat_en_i = r;
        @(posedge clk);
        @(negedge clk);
        chk(tag, e, outs(), exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'b0, "idle", i);
    endtask

    initial begin
        logic k;
        logic r;
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        bus.key_i       = 1'b0;
        bus.repeat_en_i = 1'b0;
        @(negedge clk);

        // Reset held while key toggles: everything stays low.
        step(1'b1, 1'b1, 6'b0, "rst_hold", 0);
        step(1'b0, 1'b1, 6'b0, "rst_hold", 1);
        step(1'b1, 1'b0, 6'b0, "rst_hold", 2);
        step(1'b1, 1'b0, 6'b0, "rst_hold", 3);
        // Leave reset with key already down: first edge reports press.
        rst_n = 1'b1;
        step(1'b1, 1'b0, 6'b100010, "rst_exit_press", 0);
        step(1'b0, 1'b0, 6'b010000, "rst_exit_release", 1);
        idle(8);

        // Short press: key high on edges 0..4, low at 5.
        for (int e = 0; e <= 6; e++) begin
            k = (e < 5);
            step(k, 1'b0, {e == 0, e == 5, 1'b0, 1'b0, k, 1'b0}, "short", e);
        end
        idle(8);

        // Long press with repeat: long@8, rpt@12,16, release@19.
        for (int e = 0; e <= 20; e++) begin
            k = (e < 19);
            step(k, 1'b1, {e == 0, e == 19, e == 8, (e == 12 || e == 16), k, 1'b0},
                 "long_rpt", e);
        end
        idle(8);

        // Release coincident with the long threshold: release only.
        for (int e = 0; e <= 9; e++) begin
            k = (e < 8);
            step(k, 1'b1, {e == 0, e == 8, 1'b0, 1'b0, k, 1'b0}, "collide", e);
        end
        idle(8);

        // Repeat disabled: long@8 only, release@14.
        for (int e = 0; e <= 14; e++) begin
            k = (e < 14);
            step(k, 1'b0, {e == 0, e == 14, e == 8, 1'b0, k, 1'b0}, "no_rpt", e);
        end
        idle(8);

        // Repeat enabled from edge 20 of a 30-cycle hold: rpt@24,28, release@30.
        for (int e = 0; e <= 31; e++) begin
            k = (e < 30);
            r = (e >= 20);
            step(k, r, {e == 0, e == 30, e == 8, (e == 24 || e == 28), k, 1'b0},
                 "rpt_late", e);
        end
        idle(8);

        // Reset asserted mid-LONG: outputs drop at once, no release afterwards.
        for (int e = 0; e <= 10; e++) begin
            step(1'b1, 1'b0, {e == 0, 1'b0, e == 8, 1'b0, 1'b1, 1'b0}, "pre_rst", e);
        end
        rst_n = 1'b0;
        #1;
        chk("rst_async", 0, outs(), 6'b0);
        step(1'b1, 1'b0, 6'b0, "rst_mid", 1);
        step(1'b0, 1'b0, 6'b0, "rst_mid", 2);
        rst_n = 1'b1;
        idle(3);

        // Double-click sequence: r=2, re-press@5 (r+3) -> dc; r=7, re-press@14 (r+7) -> none;
        // long release@23, re-press@25 -> none; r=26, re-press@32 (r+6, window edge) -> dc.
        for (int e = 0; e <= 36; e++) begin
            k = (e <= 1) || (e == 5) || (e == 6) || (e >= 14 && e <= 22) || (e == 25) ||
                (e == 32);
            step(k, 1'b0,
                 {(e == 0 || e == 5 || e == 14 || e == 25 || e == 32),
                  (e == 2 || e == 7 || e == 23 || e == 26 || e == 33),
                  e == 22, 1'b0, k, DcOn && (e == 5 || e == 32)},
                 "dclick", e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
